// File: rtl/contador_secuencia.sv
// Programmable sequence counter: an index walks a DEPTH-entry table forward or
// backward over an adjustable length, and Q presents the table entry at that index.
module contador_secuencia #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             C,
  input  logic             RN,
  input  logic             EN,
  input  logic             DIR,
  input  logic [AW:0]      LEN,
  input  logic             LOAD,
  input  logic [AW-1:0]    LIDX,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic [WIDTH-1:0] Q,
  output logic [AW-1:0]    IDX,
  output logic             WRAP
);

  localparam logic [AW:0] depthLen = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] seqTbl [DEPTH];
  logic [AW:0]      effLen, lastIdx, curIdx;
  logic [AW-1:0]    nxtIdx;
  logic             nxtWrap;
  logic             wrHit;

  // Out-of-range lengths (0 or above DEPTH) fall back to the full table.
  always_comb begin
    effLen  = (LEN != '0 && LEN <= depthLen) ? LEN : depthLen;
    lastIdx = effLen - (AW+1)'(1);
    curIdx  = {1'b0, IDX};
  end

  always_comb begin
    nxtIdx  = IDX;
    nxtWrap = 1'b0;
    if (LOAD) begin
      nxtIdx = ({1'b0, LIDX} < effLen) ? LIDX : '0;
    end else if (EN) begin
      if (DIR) begin
        if (curIdx >= lastIdx) begin
          nxtIdx  = '0;
          nxtWrap = 1'b1;
        end else begin
          nxtIdx = IDX + AW'(1);
        end
      end else begin
        // An index stranded beyond a freshly shrunk length re-enters at the top.
        if (IDX == '0 || curIdx >= effLen) begin
          nxtIdx  = lastIdx[AW-1:0];
          nxtWrap = 1'b1;
        end else begin
          nxtIdx = IDX - AW'(1);
        end
      end
    end
  end

  // Addresses beyond DEPTH match no entry, so such writes fall away.
  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) seqTbl[i] <= WIDTH'(i);
    end else if (WE) begin
      for (int i = 0; i < DEPTH; i++)
        if (WADDR == AW'(i)) seqTbl[i] <= WDATA;
    end
  end

  assign wrHit = WE && (WADDR == nxtIdx);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      Q    <= '0;
      IDX  <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= wrHit ? WDATA : seqTbl[nxtIdx];
      IDX  <= nxtIdx;
      WRAP <= nxtWrap;
    end
  end

endmodule
